ddr3_cmd_arbiter: RTL and testbench

- Shares the single DDR3 controller command port between one write-burst requester and one read-burst requester.
- Round-robin arbitration; each burst is qualified against write-FIFO fill and read-FIFO space before `cmd_en` is strobed.
- Enforces a settle hold-off after every issued command, because `wr_count`/`rd_count` respond slowly.
- Sits between the DMA engines and the memory-controller command FIFO.

---
 rtl/ddr3_cmd_arbiter.sv | 102 ++++++++++
 tb/tb_ddr3_cmd_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_arbiter.sv
// ddr3_cmd_arbiter: round-robin write/read burst arbiter for a shared DDR3 command port
module ddr3_cmd_arbiter #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [27:0] wr_addr,
  input  logic [5:0]  wr_bl,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [27:0] rd_addr,
  input  logic [5:0]  rd_bl,
  output logic        rd_ack,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [27:0] cmd_word_addr,
  input  logic        cmd_full,
  input  logic        cmd_empty,
  input  logic [6:0]  wr_count,
  input  logic [6:0]  rd_count,
  input  logic        wr_error,
  input  logic        rd_error,
  output logic        busy,
  output logic        last_grant,
  output logic        fault,
  output logic        timeout
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, QUAL, ISSUE, SETTLE} state_t;
  state_t state, state_n;
  logic lat_rd;
  logic [27:0] lat_addr;
  logic [5:0] lat_bl;
  logic [3:0] scnt;
  logic [TW-1:0] tcnt;
  logic err, grant, grant_rd, abort, expire, qual_ok;
  logic [6:0] bl1;
  logic [7:0] rd_need;
  logic unused_ok;
  assign unused_ok = cmd_empty;
  assign cmd_en = state == ISSUE;
  assign wr_ack = cmd_en && !lat_rd;
  assign rd_ack = cmd_en && lat_rd;
  assign busy = state != IDLE;
  // grant choice, qualification and next state; abort beats timeout beats issue
  always_comb begin
    err = wr_error | rd_error;
    grant = !fault && !err && (wr_req || rd_req);
    grant_rd = rd_req && (!wr_req || !last_grant);
    abort = err || (lat_rd ? !rd_req : !wr_req);
    expire = (TIMEOUT_CYCLES != 0) && tcnt == TW'(1);
    bl1 = {1'b0, lat_bl} + 7'd1;
    rd_need = {1'b0, rd_count} + {2'b0, lat_bl} + 8'd1;
    qual_ok = !cmd_full && (lat_rd ? rd_need <= 8'(FIFO_DEPTH) : wr_count >= bl1);
    state_n = state == IDLE  ? (grant ? QUAL : IDLE) :
              state == QUAL  ? (abort || expire ? IDLE : qual_ok ? ISSUE : QUAL) :
              state == ISSUE ? SETTLE :
              (scnt == 4'd0 ? IDLE : SETTLE);
  end
  // state, latched request, counters, command outputs and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lat_rd <= 1'b0;
      lat_addr <= '0;
      lat_bl <= '0;
      scnt <= '0;
      tcnt <= '0;
      cmd_instr <= '0;
      cmd_bl <= '0;
      cmd_word_addr <= '0;
      last_grant <= 1'b1;
      fault <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (err) fault <= 1'b1;
      if (state == IDLE && grant) begin
        lat_rd <= grant_rd;
        lat_addr <= grant_rd ? rd_addr : wr_addr;
        lat_bl <= grant_rd ? rd_bl : wr_bl;
        last_grant <= grant_rd;
        tcnt <= TW'(TIMEOUT_CYCLES);
      end
      if (state == QUAL) begin
        tcnt <= tcnt - TW'(1);
        if (!abort && expire) timeout <= 1'b1;
        if (state_n == ISSUE) begin
          cmd_instr <= {2'b00, lat_rd};
          cmd_bl <= lat_bl;
          cmd_word_addr <= lat_addr;
        end
      end
      if (state == ISSUE) scnt <= 4'(SETTLE_CYCLES - 1);
      if (state == SETTLE) scnt <= scnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// tb_ddr3_cmd_arbiter: scoreboard bench for the DDR3 command arbiter
module tb_ddr3_cmd_arbiter;
  localparam int SETTLE = 4;
  localparam int TMO = 16;
  localparam int DEPTH = 64;
  logic clk = 0, rst = 1;
  logic wr_req = 0, rd_req = 0, cmd_full = 0, cmd_empty = 1, wr_error = 0, rd_error = 0;
  logic [27:0] wr_addr = 0, rd_addr = 0, cmd_word_addr;
  logic [5:0] wr_bl = 0, rd_bl = 0, cmd_bl;
  logic [6:0] wr_count = 0, rd_count = 0;
  logic wr_ack, rd_ack, cmd_en, busy, last_grant, fault, timeout;
  logic [2:0] cmd_instr;
  int errors = 0, checks = 0;
  typedef struct packed {logic [2:0] instr; logic [5:0] bl; logic [27:0] addr;} cmd_t;
  cmd_t exp_q[$];

  ddr3_cmd_arbiter #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_bl(wr_bl), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_bl(rd_bl), .rd_ack(rd_ack), .cmd_en(cmd_en),
    .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_word_addr(cmd_word_addr), .cmd_full(cmd_full),
    .cmd_empty(cmd_empty), .wr_count(wr_count), .rd_count(rd_count), .wr_error(wr_error),
    .rd_error(rd_error), .busy(busy), .last_grant(last_grant), .fault(fault), .timeout(timeout));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every command strobe is matched against the oldest expected command
  always @(negedge clk) begin
    if (cmd_en) begin
      if (exp_q.size() == 0) chk("sb_unexpected_cmd", 1, 0);
      else begin
        cmd_t e;
        e = exp_q.pop_front();
        chk("sb_instr", cmd_instr, e.instr);
        chk("sb_bl", cmd_bl, e.bl);
        chk("sb_addr", cmd_word_addr, e.addr);
        chk("sb_acks", {wr_ack, rd_ack}, {e.instr == 3'd0, e.instr == 3'd1});
      end
    end else if (wr_ack || rd_ack) chk("sb_ack_without_cmd", {wr_ack, rd_ack}, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic wait_cmd(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (cmd_en) return;
    end
    n = -1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    if (busy) chk({name, "_idle_bound"}, busy, 0);
  endtask

  task automatic quiet(input int cycles, output logic seen);
    seen = 0;
    repeat (cycles) begin
      tick();
      seen |= cmd_en | wr_ack | rd_ack;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int t[4];
    logic seen, got_ack;
    do_reset();
    chk("rst_outputs", {cmd_en, wr_ack, rd_ack, busy, fault, timeout, last_grant}, 7'b0000001);
    chk("rst_cmd_fields", {cmd_instr, cmd_bl, cmd_word_addr}, 0);

    // write only
    wr_count = 16; wr_bl = 15; wr_addr = 28'h100;
    exp_q.push_back('{3'd0, 6'd15, 28'h100});
    wr_req = 1;
    wait_cmd(10, n);
    chk("wr_latency", n, 2);
    wr_req = 0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("wr_busy_settle", n, SETTLE + 1);
    chk("wr_hold_fields", {cmd_en, cmd_instr, cmd_bl, cmd_word_addr}, {1'b0, 3'd0, 6'd15, 28'h100});
    chk("wr_last_grant", last_grant, 0);

    // write starvation then release
    wr_count = 8; wr_addr = 28'h200;
    exp_q.push_back('{3'd0, 6'd15, 28'h200});
    wr_req = 1;
    quiet(8, seen);
    chk("starve_no_cmd", seen, 0);
    wr_count = 16;
    wait_cmd(10, n);
    chk("starve_release_latency", n, 1);
    wr_req = 0;
    wait_idle("starve");

    // write starvation until timeout
    wr_count = 8; wr_addr = 28'h2a0;
    wr_req = 1;
    tick();
    got_ack = 0; n = 0;
    while (!timeout && n < 40) begin tick(); n++; got_ack |= wr_ack | cmd_en; end
    chk("timeout_cycles", n, TMO);
    chk("timeout_no_ack", got_ack, 0);
    chk("timeout_idle", busy, 0);
    chk("timeout_last_grant", last_grant, 0);
    wr_req = 0;

    // read space qualification
    rd_count = 40; rd_bl = 31; rd_addr = 28'h300;
    exp_q.push_back('{3'd1, 6'd31, 28'h300});
    rd_req = 1;
    quiet(6, seen);
    chk("rd_blocked", seen, 0);
    rd_count = 32;
    wait_cmd(10, n);
    chk("rd_release_latency", n, 1);
    rd_req = 0;
    wait_idle("rd");
    chk("rd_last_grant", last_grant, 1);

    // command FIFO full while otherwise qualified
    wr_count = 64; wr_bl = 3; wr_addr = 28'h400; cmd_full = 1;
    exp_q.push_back('{3'd0, 6'd3, 28'h400});
    wr_req = 1;
    quiet(11, seen);
    chk("full_no_cmd", seen, 0);
    cmd_full = 0;
    wait_cmd(10, n);
    chk("full_release_latency", n, 1);
    wr_req = 0;
    wait_idle("full");

    // read request dropped in QUAL
    rd_count = 40; rd_bl = 31; rd_addr = 28'h4a0;
    rd_req = 1;
    repeat (4) tick();
    rd_req = 0;
    quiet(10, seen);
    chk("abort_no_cmd", seen, 0);
    chk("abort_idle", busy, 0);

    // error during QUAL: abort and lock out
    wr_count = 8; wr_bl = 15; wr_addr = 28'h4c0;
    wr_req = 1;
    repeat (3) tick();
    wr_error = 1;
    tick();
    wr_error = 0;
    chk("err_fault", fault, 1);
    chk("err_abort", busy, 0);
    wr_req = 0;
    tick();
    wr_count = 64;
    wr_req = 1;
    quiet(10, seen);
    chk("err_locked_no_cmd", {seen, busy}, 0);
    wr_req = 0;

    // reset clears everything and the next request is served
    do_reset();
    chk("rst2_flags", {fault, timeout, busy, last_grant}, 4'b0001);
    chk("rst2_fields", {cmd_instr, cmd_bl, cmd_word_addr}, 0);
    wr_bl = 7; wr_addr = 28'h500;
    exp_q.push_back('{3'd0, 6'd7, 28'h500});
    wr_req = 1;
    wait_cmd(10, n);
    chk("rst2_latency", n, 2);
    wr_req = 0;
    wait_idle("rst2");

    // round robin with both requests held
    do_reset();
    wr_count = 64; rd_count = 0; wr_bl = 5; rd_bl = 9; wr_addr = 28'h600; rd_addr = 28'h700;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(i % 2 == 0 ? cmd_t'{3'd0, 6'd5, 28'h600} : cmd_t'{3'd1, 6'd9, 28'h700});
    wr_req = 1; rd_req = 1;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (cmd_en) begin t[n] = c; n++; end
    end
    wr_req = 0; rd_req = 0;
    chk("rr_count", n, 4);
    for (int i = 1; i < 4; i++) chk("rr_spacing", t[i] - t[i-1], SETTLE + 3);
    wait_idle("rr");

    // randomized single-requester transactions against the spec rules
    do_reset();
    for (int k = 0; k < 30; k++) begin
      logic is_rd, full, qual;
      logic [5:0] bl;
      logic [27:0] addr;
      int cnt;
      is_rd = 1'($urandom_range(0, 1));
      bl = 6'($urandom_range(0, 63));
      addr = 28'($urandom);
      cnt = $urandom_range(0, 64);
      full = $urandom_range(0, 7) == 0;
      qual = !full && (is_rd ? (cnt + bl + 1 <= DEPTH) : (cnt >= bl + 1));
      cmd_full = full;
      if (is_rd) begin rd_count = 7'(cnt); rd_bl = bl; rd_addr = addr; end
      else begin wr_count = 7'(cnt); wr_bl = bl; wr_addr = addr; end
      if (qual) exp_q.push_back('{{2'b00, is_rd}, bl, addr});
      if (is_rd) rd_req = 1; else wr_req = 1;
      got_ack = 0; n = 0;
      while (!got_ack && !timeout && n < 30) begin
        tick();
        n++;
        got_ack = is_rd ? rd_ack : wr_ack;
      end
      rd_req = 0; wr_req = 0;
      chk("rand_ack", got_ack, qual);
      chk("rand_timeout", timeout, !qual);
      wait_idle("rand");
      if (timeout) do_reset();
      cmd_full = 0;
    end

    repeat (5) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
